shift_sequencer: RTL

Multi-cycle shift controller for the lab shift-register datapath. It loads an operand, then sequences a shift register one bit position per clock for a requested number of steps. Four shift modes are supported. It reports completion with a start/busy/done handshake, and a top level uses it to turn single-step shift registers into a variable-amount shifter.

---
 rtl/shift_sequencer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shift controller.
//
// Loads an operand on an accepted start, then shifts it one bit position per
// clock for the requested number of steps. It reports completion through a
// start/busy/done handshake.
//
// Parameters:
//   WIDTH   datapath width in bits
//   CNTW    width of the shift-amount field (2**CNTW must exceed WIDTH)
//
// Ports:
//   clock    rising-edge clock
//   reset    synchronous active-high reset; overrides every other input
//   start    operation request, sampled only in idle
//   mode     00 lsl, 01 lsr, 10 asr, 11 rotate left; captured with start
//   amount   number of single-bit shifts; captured with start
//   abort    stops an operation that is shifting
//   D        operand, captured with start
//   Q        shift register contents
//   busy     high whenever the sequencer is not idle
//   done     one-cycle completion pulse
//   aborted  one-cycle abort pulse
module shift_sequencer #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned CNTW  = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNTW-1:0]  amount,
    input  logic             abort,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StDone  = 2'b10
    } state_e;

    localparam logic [1:0] ModeLsl = 2'b00;
    localparam logic [1:0] ModeLsr = 2'b01;
    localparam logic [1:0] ModeAsr = 2'b10;
    localparam logic [1:0] ModeRol = 2'b11;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic             aborted_q, aborted_d;

    // Single-step shift of the current register contents in the captured mode.
    logic [WIDTH-1:0] q_shifted;

    always_comb begin
        q_shifted = q_q;
        unique case (mode_q)
            ModeLsl: q_shifted = {q_q[WIDTH-2:0], 1'b0};
            ModeLsr: q_shifted = {1'b0, q_q[WIDTH-1:1]};
            ModeAsr: q_shifted = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
            ModeRol: q_shifted = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            default: q_shifted = q_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        aborted_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    q_d    = D;
                    mode_d = mode;
                    cnt_d  = amount;
                    // A zero amount skips shifting and completes straight away.
                    state_d = (amount != '0) ? StShift : StDone;
                end
            end
            StShift: begin
                // Abort wins over the final shift: the partial value is kept.
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    q_d   = q_shifted;
                    cnt_d = cnt_q - CNTW'(1);
                    if (cnt_q == CNTW'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            q_q       <= '0;
            cnt_q     <= '0;
            mode_q    <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            aborted_q <= aborted_d;
        end
    end

    // All outputs come from registers or the state decode only.
    assign Q       = q_q;
    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StDone);
    assign aborted = aborted_q;

endmodule
